branch_recovery_unit: RTL and testbench

// Receiving end of the branch FU resolve interface. Keeps a program-ordered checkpoint queue (ROB tag + free-list head)
// for each in-flight JALR/BNE allocated at dispatch; frees entries on correct resolve. On mispredict: sequences
// ROB/RS flush, rename free-list restore, fetch redirect; stalls dispatch until redirect accepted.

---
 rtl/branch_recovery_unit.sv | 201 ++++++++++++++++++++
 tb/tb_branch_recovery_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_recovery_unit.sv
// Branch recovery unit: program-ordered checkpoint queue for in-flight branches,
// freed on correct resolve; a mispredict runs the flush -> restore -> redirect
// sequence and holds dispatch until fetch accepts the redirect.
module branch_recovery_unit #(
  parameter int unsigned NCKPT     = 4,
  parameter int unsigned ROB_TAG_W = 5,
  parameter int unsigned FL_PTR_W  = 6,
  parameter int unsigned PC_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ckpt_alloc_valid,
  input  logic [ROB_TAG_W-1:0] ckpt_alloc_rob,
  input  logic [FL_PTR_W-1:0]  ckpt_alloc_fl,
  output logic                 ckpt_alloc_ready,
  input  logic                 br_done,
  input  logic [ROB_TAG_W-1:0] br_rob_tag,
  input  logic                 br_mispredict,
  input  logic [PC_W-1:0]      br_target_pc,
  output logic                 flush_valid,
  output logic [ROB_TAG_W-1:0] flush_rob_tag,
  output logic                 restore_valid,
  output logic [FL_PTR_W-1:0]  restore_fl,
  output logic                 redirect_valid,
  output logic [PC_W-1:0]      redirect_pc,
  input  logic                 redirect_ready,
  output logic                 busy,
  output logic                 err_unknown_tag
);

  localparam int unsigned IdxW = (NCKPT > 1) ? $clog2(NCKPT) : 1;
  localparam int unsigned CntW = IdxW + 1;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StFlush    = 2'd1;
  localparam logic [1:0] StRestore  = 2'd2;
  localparam logic [1:0] StRedirect = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NCKPT-1:0]     valid_q, valid_d;
  logic [NCKPT-1:0]     res_q, res_d;
  logic [IdxW-1:0]      head_q, head_d;
  logic [IdxW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [IdxW-1:0]      lat_idx_q, lat_idx_d;
  logic [ROB_TAG_W-1:0] lat_tag_q, lat_tag_d;
  logic [FL_PTR_W-1:0]  lat_fl_q, lat_fl_d;
  logic [PC_W-1:0]      lat_pc_q, lat_pc_d;
  logic                 err_q, err_d;

  logic [ROB_TAG_W-1:0] rob_q [NCKPT];
  logic [FL_PTR_W-1:0]  fl_q  [NCKPT];

  logic            is_idle;
  logic            hit;
  logic [IdxW-1:0] hit_idx;
  logic [IdxW-1:0] hit_age;
  logic [IdxW-1:0] lat_age;
  logic            older_ok;
  logic            mp_take;
  logic            ok_take;
  logic            err_set;
  logic            alloc_fire;
  logic            exit_redirect;
  logic            pop;

  assign is_idle = (state_q == StIdle);

  // Find the live (allocated, not yet resolved) entry holding the resolving tag.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NCKPT; i++) begin
      if (!hit && valid_q[i] && !res_q[i] && (rob_q[i] == br_rob_tag)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  assign hit_age = hit_idx - head_q;
  assign lat_age = lat_idx_q - head_q;
  // While recovering, only entries strictly older than the latched branch matter.
  assign older_ok = is_idle || (hit_age < lat_age);

  assign mp_take       = br_done && br_mispredict && hit && older_ok;
  assign ok_take       = br_done && !br_mispredict && hit && older_ok;
  // Misses during recovery are usually squashed tags, so they are not errors.
  assign err_set       = br_done && !hit && is_idle;
  assign alloc_fire    = ckpt_alloc_valid && ckpt_alloc_ready && !mp_take;
  assign exit_redirect = (state_q == StRedirect) && redirect_ready && !mp_take;
  // A correct resolve of the head entry frees it in the same cycle.
  assign pop = valid_q[head_q] &&
               (res_q[head_q] || (ok_take && (hit_idx == head_q)));

  // Next-state for queue bookkeeping, latched recovery info and the FSM.
  always_comb begin
    valid_d   = valid_q;
    res_d     = res_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    state_d   = state_q;
    lat_idx_d = lat_idx_q;
    lat_tag_d = lat_tag_q;
    lat_fl_d  = lat_fl_q;
    lat_pc_d  = lat_pc_q;
    err_d     = err_q | err_set;

    if (ok_take) res_d[hit_idx] = 1'b1;
    if (exit_redirect) res_d[lat_idx_q] = 1'b1;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      res_d[head_q]   = 1'b0;
      head_d          = head_q + IdxW'(1);
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      res_d[tail_q]   = 1'b0;
      tail_d          = tail_q + IdxW'(1);
    end

    if (mp_take) begin
      // Discard everything younger than the mispredicted branch.
      for (int i = 0; i < NCKPT; i++) begin
        if ((IdxW'(i) - head_q) > hit_age) begin
          valid_d[i] = 1'b0;
          res_d[i]   = 1'b0;
        end
      end
      tail_d    = hit_idx + IdxW'(1);
      // The mispredicted entry survives, so equal pointers mean full, not empty.
      count_d   = (tail_d == head_d) ? CntW'(NCKPT) : {1'b0, tail_d - head_d};
      lat_idx_d = hit_idx;
      lat_tag_d = br_rob_tag;
      lat_fl_d  = fl_q[hit_idx];
      lat_pc_d  = br_target_pc;
    end else begin
      count_d = count_q + CntW'(alloc_fire) - CntW'(pop);
    end

    case (state_q)
      StIdle:     state_d = StIdle;
      StFlush:    state_d = StRestore;
      StRestore:  state_d = StRedirect;
      StRedirect: state_d = redirect_ready ? StIdle : StRedirect;
      default:    state_d = StIdle;
    endcase
    if (mp_take) state_d = StFlush;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      res_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      lat_idx_q <= '0;
      lat_tag_q <= '0;
      lat_fl_q  <= '0;
      lat_pc_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      lat_idx_q <= lat_idx_d;
      lat_tag_q <= lat_tag_d;
      lat_fl_q  <= lat_fl_d;
      lat_pc_q  <= lat_pc_d;
      err_q     <= err_d;
    end
  end

  // Checkpoint payload; qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rob_q[tail_q] <= ckpt_alloc_rob;
      fl_q[tail_q]  <= ckpt_alloc_fl;
    end
  end

  assign ckpt_alloc_ready = (count_q < CntW'(NCKPT)) && is_idle;
  assign flush_valid      = (state_q == StFlush);
  assign restore_valid    = (state_q == StRestore);
  assign redirect_valid   = (state_q == StRedirect);
  assign flush_rob_tag    = lat_tag_q;
  assign restore_fl       = lat_fl_q;
  assign redirect_pc      = lat_pc_q;
  assign busy             = !is_idle;
  assign err_unknown_tag  = err_q;

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Self-checking bench for branch_recovery_unit: recovery sequences are checked
// against a scoreboard of expected (tag, free-list head, target, timing) tuples.
module tb_branch_recovery_unit;

  localparam int unsigned NCKPT     = 4;
  localparam int unsigned ROB_TAG_W = 5;
  localparam int unsigned FL_PTR_W  = 6;
  localparam int unsigned PC_W      = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ckpt_alloc_valid;
  logic [ROB_TAG_W-1:0] ckpt_alloc_rob;
  logic [FL_PTR_W-1:0]  ckpt_alloc_fl;
  logic                 ckpt_alloc_ready;
  logic                 br_done;
  logic [ROB_TAG_W-1:0] br_rob_tag;
  logic                 br_mispredict;
  logic [PC_W-1:0]      br_target_pc;
  logic                 flush_valid;
  logic [ROB_TAG_W-1:0] flush_rob_tag;
  logic                 restore_valid;
  logic [FL_PTR_W-1:0]  restore_fl;
  logic                 redirect_valid;
  logic [PC_W-1:0]      redirect_pc;
  logic                 redirect_ready;
  logic                 busy;
  logic                 err_unknown_tag;

  branch_recovery_unit #(
    .NCKPT    (NCKPT),
    .ROB_TAG_W(ROB_TAG_W),
    .FL_PTR_W (FL_PTR_W),
    .PC_W     (PC_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ckpt_alloc_valid(ckpt_alloc_valid),
    .ckpt_alloc_rob  (ckpt_alloc_rob),
    .ckpt_alloc_fl   (ckpt_alloc_fl),
    .ckpt_alloc_ready(ckpt_alloc_ready),
    .br_done         (br_done),
    .br_rob_tag      (br_rob_tag),
    .br_mispredict   (br_mispredict),
    .br_target_pc    (br_target_pc),
    .flush_valid     (flush_valid),
    .flush_rob_tag   (flush_rob_tag),
    .restore_valid   (restore_valid),
    .restore_fl      (restore_fl),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready),
    .busy            (busy),
    .err_unknown_tag (err_unknown_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          fl;
    logic [31:0] pc;
    int          t;     // cycle number of the edge that samples the mispredict
    int          hold;  // redirect cycles before acceptance, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   red_cnt = 0;
  bit   mon_acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    mon_acc = redirect_valid && redirect_ready && !reset;
    #1;
    if (mon_acc && exp_q.size() > 0) begin
      if (exp_q[0].hold != 0) check_eq("redirect_hold", red_cnt, exp_q[0].hold);
      exp_q.delete(0);
      red_cnt = 0;
    end
    if (flush_valid) begin
      if (exp_q.size() == 0) check_eq("spurious_flush", 32'(flush_valid), 0);
      else begin
        check_eq("flush_tag", 32'(flush_rob_tag), exp_q[0].tag);
        check_eq("flush_lat", cyc, exp_q[0].t);
        red_cnt = 0;
      end
    end
    if (restore_valid) begin
      if (exp_q.size() == 0) check_eq("spurious_restore", 32'(restore_valid), 0);
      else begin
        check_eq("restore_fl", 32'(restore_fl), exp_q[0].fl);
        check_eq("restore_lat", cyc, exp_q[0].t + 1);
      end
    end
    if (redirect_valid) begin
      if (exp_q.size() == 0) check_eq("spurious_redirect", 32'(redirect_valid), 0);
      else begin
        check_eq("redirect_pc", redirect_pc, exp_q[0].pc);
        if (red_cnt == 0) check_eq("redirect_lat", cyc, exp_q[0].t + 2);
        red_cnt++;
      end
    end
  end

  // All drive tasks start and end on a falling edge.
  task automatic reset_dut();
    reset = 1'b1;
    ckpt_alloc_valid = 1'b0;
    br_done = 1'b0;
    br_mispredict = 1'b0;
    redirect_ready = 1'b0;
    exp_q.delete();
    red_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic alloc(input int rob, input int fl);
    ckpt_alloc_valid = 1'b1;
    ckpt_alloc_rob   = ROB_TAG_W'(rob);
    ckpt_alloc_fl    = FL_PTR_W'(fl);
    @(negedge clk);
    ckpt_alloc_valid = 1'b0;
  endtask

  task automatic resolve(input int rob, input bit mp, input logic [31:0] pc);
    br_done       = 1'b1;
    br_rob_tag    = ROB_TAG_W'(rob);
    br_mispredict = mp;
    br_target_pc  = pc;
    @(negedge clk);
    br_done       = 1'b0;
    br_mispredict = 1'b0;
  endtask

  task automatic push_exp(input int tag, input int fl, input logic [31:0] pc, input int hold);
    exp_t e;
    e.tag = tag; e.fl = fl; e.pc = pc; e.t = cyc + 1; e.hold = hold;
    exp_q.push_back(e);
  endtask

  task automatic wait_redirect();
    int n = 0;
    while (!redirect_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!redirect_valid) check_eq("redirect_timeout", 32'(redirect_valid), 1);
  endtask

  task automatic redirect_accept(input int hold);
    wait_redirect();
    if (redirect_valid) begin
      repeat (hold - 1) @(negedge clk);
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
    end
  endtask

  // Fill from an empty queue: ready stays up for three, drops after the fourth.
  task automatic fill_check(input int base, input string tag);
    for (int i = 0; i < 3; i++) alloc(base + i, base + i);
    check_eq({tag, "_ready3"}, 32'(ckpt_alloc_ready), 1);
    alloc(base + 3, base + 3);
    check_eq({tag, "_ready4"}, 32'(ckpt_alloc_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ckpt_alloc_rob = '0;
    ckpt_alloc_fl  = '0;
    br_rob_tag     = '0;
    br_target_pc   = '0;
    @(negedge clk);
    reset_dut();

    // Reset state
    check_eq("rst_ready", 32'(ckpt_alloc_ready), 1);
    check_eq("rst_flush", 32'(flush_valid), 0);
    check_eq("rst_restore", 32'(restore_valid), 0);
    check_eq("rst_redirect", 32'(redirect_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_err", 32'(err_unknown_tag), 0);
    check_eq("rst_tag", 32'(flush_rob_tag), 0);
    check_eq("rst_fl", 32'(restore_fl), 0);
    check_eq("rst_pc", redirect_pc, 0);

    // 1: fill, then free the head
    alloc(3, 1); alloc(5, 2); alloc(7, 3);
    check_eq("t1_ready3", 32'(ckpt_alloc_ready), 1);
    alloc(9, 4);
    check_eq("t1_full", 32'(ckpt_alloc_ready), 0);
    resolve(3, 1'b0, 0);
    check_eq("t1_ready_pop", 32'(ckpt_alloc_ready), 1);

    // 2: mispredict of a middle entry, redirect held 3 cycles
    reset_dut();
    alloc(3, 10); alloc(5, 11); alloc(7, 12);
    resolve(3, 1'b0, 0);
    push_exp(5, 11, 32'h100, 3);
    resolve(5, 1'b1, 32'h100);
    check_eq("t2_busy", 32'(busy), 1);
    check_eq("t2_ready_busy", 32'(ckpt_alloc_ready), 0);
    redirect_accept(3);
    check_eq("t2_idle", 32'(busy), 0);
    check_eq("t2_ready_idle", 32'(ckpt_alloc_ready), 1);
    fill_check(10, "t2");

    // 3: out-of-order correct resolves
    reset_dut();
    alloc(3, 1); alloc(5, 2);
    resolve(5, 1'b0, 0);
    resolve(3, 1'b0, 0);
    fill_check(20, "t3");
    check_eq("t3_err", 32'(err_unknown_tag), 0);

    // 4: older mispredict preempts a recovery in REDIRECT
    reset_dut();
    alloc(3, 20); alloc(5, 21); alloc(7, 22); alloc(9, 23);
    push_exp(7, 22, 32'h200, 0);
    resolve(7, 1'b1, 32'h200);
    wait_redirect();
    exp_q.delete(exp_q.size() - 1);
    push_exp(3, 20, 32'h300, 2);
    resolve(3, 1'b1, 32'h300);
    check_eq("t4_flush_pre", 32'(flush_rob_tag), 3);
    resolve(9, 1'b1, 32'h900);
    redirect_accept(2);
    check_eq("t4_err", 32'(err_unknown_tag), 0);
    check_eq("t4_idle", 32'(busy), 0);

    // 5: unknown tag is sticky and leaves the queue alone
    reset_dut();
    alloc(3, 1); alloc(5, 2);
    resolve(20, 1'b0, 0);
    check_eq("t5_err", 32'(err_unknown_tag), 1);
    repeat (3) @(negedge clk);
    check_eq("t5_err_sticky", 32'(err_unknown_tag), 1);
    resolve(3, 1'b0, 0);
    resolve(5, 1'b0, 0);
    fill_check(24, "t5");

    // 6: pointer wrap, then reset in the middle of a recovery
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      alloc(i, i);
      resolve(i, 1'b0, 0);
      check_eq("t6_pair_ready", 32'(ckpt_alloc_ready), 1);
    end
    alloc(1, 5); alloc(2, 6);
    push_exp(1, 5, 32'h440, 0);
    resolve(1, 1'b1, 32'h440);
    begin
      int n = 0;
      while (!restore_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("t6_restore_seen", 32'(restore_valid), 1);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("t6_flush", 32'(flush_valid), 0);
    check_eq("t6_restore", 32'(restore_valid), 0);
    check_eq("t6_redirect", 32'(redirect_valid), 0);
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_ready", 32'(ckpt_alloc_ready), 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    fill_check(12, "t6");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
